// File: rtl/meteor_field.sv
`default_nettype none
// ============================================================================
// meteor_field: four-slot meteor spawner/mover with dodge scoring for the dodge game.
// Option macro: METEOR_SPEEDUP_EN (fall speed +1 every SPEEDUP_DODGES dodges). Rev 1.0
// ============================================================================
module meteor_field #(
  parameter int unsigned  SPAWN_PERIOD   = 60,
  parameter int unsigned  SIZE_MIN       = 8,
  parameter int unsigned  Y_LIMIT        = 479,
  parameter int unsigned  X_SPAN         = 640,
  parameter int unsigned  BASE_SPEED     = 2,
  parameter logic [15:0]  LFSR_SEED      = 16'hACE1,
  parameter int unsigned  SPEEDUP_DODGES = 8
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        game_run,
  input  logic        Ball_die,
  output logic [9:0]  enemy_x [4],
  output logic [9:0]  enemy_y [4],
  output logic [9:0]  enemy_size [4],
  output logic        enermy_alive [4],
  output logic [15:0] score,
  output logic [3:0]  speed,
  output logic [1:0]  game_state
);

  localparam int unsigned CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [9:0]         x_q [4], x_d [4];
  logic [9:0]         y_q [4], y_d [4];
  logic [9:0]         size_q [4], size_d [4];
  logic               alive_q [4], alive_d [4];
  logic [15:0]        score_q, score_d;
  logic [3:0]         speed_q, speed_d;
`ifdef METEOR_SPEEDUP_EN
  logic [7:0]         dodge_q, dodge_d;
`else
  logic [7:0]         unused_speedup;
  assign unused_speedup = 8'(SPEEDUP_DODGES);
`endif

  logic [9:0]  spawn_size;
  logic [10:0] spawn_limit;
  logic [9:0]  spawn_x;

  // Out-of-range raw X folds down by 512, which keeps x + size inside the screen.
  assign spawn_size  = 10'(SIZE_MIN) + {5'd0, lfsr_q[14:10]};
  assign spawn_limit = 11'(X_SPAN) - {1'b0, spawn_size};
  assign spawn_x     = ({1'b0, lfsr_q[9:0]} <= spawn_limit) ? lfsr_q[9:0]
                                                            : lfsr_q[9:0] - 10'd512;

  always_comb begin : c_next
    logic [10:0] y_nxt;
    logic [2:0]  n_ret;
    logic        found;
    logic [16:0] score_sum;
`ifdef METEOR_SPEEDUP_EN
    logic [7:0]  dodge_sum;
`endif
    y_nxt     = '0;
    n_ret     = '0;
    found     = 1'b0;
    score_sum = '0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    score_d   = score_q;
    speed_d   = speed_q;
    x_d       = x_q;
    y_d       = y_q;
    size_d    = size_q;
    alive_d   = alive_q;
    lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
`ifdef METEOR_SPEEDUP_EN
    dodge_sum = '0;
    dodge_d   = dodge_q;
`endif

    case (state_q)
      ST_IDLE: begin
        for (int i = 0; i < 4; i++) begin
          alive_d[i] = 1'b0;
          x_d[i]     = '0;
          y_d[i]     = '0;
          size_d[i]  = '0;
        end
        if (game_run) begin
          state_d = ST_RUN;
          score_d = '0;
          speed_d = 4'(BASE_SPEED);
          cnt_d   = '0;
`ifdef METEOR_SPEEDUP_EN
          dodge_d = '0;
`endif
        end
      end

      ST_RUN: begin
        if (Ball_die) begin
          state_d = ST_FROZEN;
        end else if (!game_run) begin
          state_d = ST_IDLE;
          for (int i = 0; i < 4; i++) begin
            alive_d[i] = 1'b0;
            x_d[i]     = '0;
            y_d[i]     = '0;
            size_d[i]  = '0;
          end
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (alive_q[i]) begin
              y_nxt = {1'b0, y_q[i]} + {7'd0, speed_q};
              if (y_nxt > 11'(Y_LIMIT)) begin
                alive_d[i] = 1'b0;
                x_d[i]     = '0;
                y_d[i]     = '0;
                size_d[i]  = '0;
                n_ret      = n_ret + 3'd1;
              end else begin
                y_d[i] = y_nxt[9:0];
              end
            end
          end

          // Eligibility uses the registered alive flags, so a slot retiring now stays empty.
          if (cnt_q == CNT_W'(SPAWN_PERIOD - 1)) begin
            cnt_d = '0;
            for (int i = 0; i < 4; i++) begin
              if (!found && !alive_q[i]) begin
                found      = 1'b1;
                alive_d[i] = 1'b1;
                x_d[i]     = spawn_x;
                y_d[i]     = '0;
                size_d[i]  = spawn_size;
              end
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end

          score_sum = {1'b0, score_q} + {14'd0, n_ret};
          score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];

`ifdef METEOR_SPEEDUP_EN
          // Dodge counter runs modulo SPEEDUP_DODGES; each wrap is one crossing.
          dodge_sum = dodge_q + {5'd0, n_ret};
          if (dodge_sum >= 8'(SPEEDUP_DODGES)) begin
            dodge_d = dodge_sum - 8'(SPEEDUP_DODGES);
            speed_d = (speed_q >= 4'd7) ? 4'd7 : speed_q + 4'd1;
          end else begin
            dodge_d = dodge_sum;
          end
`endif
        end
      end

      ST_FROZEN: begin
        if (!game_run) begin
          state_d = ST_IDLE;
          for (int i = 0; i < 4; i++) begin
            alive_d[i] = 1'b0;
            x_d[i]     = '0;
            y_d[i]     = '0;
            size_d[i]  = '0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_SEED;
      cnt_q   <= '0;
      score_q <= '0;
      speed_q <= 4'(BASE_SPEED);
      for (int i = 0; i < 4; i++) begin
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        size_q[i]  <= '0;
        alive_q[i] <= 1'b0;
      end
`ifdef METEOR_SPEEDUP_EN
      dodge_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      score_q <= score_d;
      speed_q <= speed_d;
      for (int i = 0; i < 4; i++) begin
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
        size_q[i]  <= size_d[i];
        alive_q[i] <= alive_d[i];
      end
`ifdef METEOR_SPEEDUP_EN
      dodge_q <= dodge_d;
`endif
    end
  end

  assign enemy_x      = x_q;
  assign enemy_y      = y_q;
  assign enemy_size   = size_q;
  assign enermy_alive = alive_q;
  assign score        = score_q;
  assign speed        = speed_q;
  assign game_state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_meteor_field.sv
`default_nettype none
// ============================================================================
// tb_meteor_field: directed self-checking bench for meteor_field (SPAWN_PERIOD = 10).
// Rev 1.0
// ============================================================================
module tb_meteor_field;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic        game_run;
  logic        Ball_die;
  logic [9:0]  enemy_x [4];
  logic [9:0]  enemy_y [4];
  logic [9:0]  enemy_size [4];
  logic        enermy_alive [4];
  logic [15:0] score;
  logic [3:0]  speed;
  logic [1:0]  game_state;

  int          checks = 0;
  int          errors = 0;
  int          frame  = 0;
  logic [15:0] m_lfsr;
  logic [15:0] pre_lfsr;

  meteor_field #(.SPAWN_PERIOD(10)) dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .game_run    (game_run),
    .Ball_die    (Ball_die),
    .enemy_x     (enemy_x),
    .enemy_y     (enemy_y),
    .enemy_size  (enemy_size),
    .enermy_alive(enermy_alive),
    .score       (score),
    .speed       (speed),
    .game_state  (game_state)
  );

  always #5 frame_clk = ~frame_clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [9:0] exp_size(input logic [15:0] l);
    return 10'd8 + {5'd0, l[14:10]};
  endfunction

  function automatic logic [9:0] exp_x(input logic [15:0] l);
    logic [10:0] lim;
    lim = 11'd640 - {1'b0, exp_size(l)};
    if ({1'b0, l[9:0]} <= lim) return l[9:0];
    return l[9:0] - 10'd512;
  endfunction

  // One frame edge; pre_lfsr holds the LFSR value the DUT sees on that edge.
  task automatic tick();
    pre_lfsr = m_lfsr;
    @(posedge frame_clk);
    if (Reset) m_lfsr = SEED;
    else       m_lfsr = lfsr_next(m_lfsr);
    frame++;
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; game_run = 1'b1; Ball_die = 1'b0; m_lfsr = SEED;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (enermy_alive[i] !== 1'b0 || enemy_x[i] !== 10'd0 || enemy_y[i] !== 10'd0 || enemy_size[i] !== 10'd0) begin
        errors++;
        $display("FAIL reset_slot%0d: alive=%0d x=%0d y=%0d size=%0d expected all 0", i,
                 enermy_alive[i], enemy_x[i], enemy_y[i], enemy_size[i]);
      end
    end
    checks++;
    if (score !== 16'd0) begin errors++; $display("FAIL reset_score: got %0d expected 0", score); end
    checks++;
    if (speed !== 4'd2) begin errors++; $display("FAIL reset_speed: got %0d expected 2", speed); end
    checks++;
    if (game_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", game_state); end
    Reset = 1'b0;
    tick();
    frame = 0;
    checks++;
    if (game_state !== 2'd1) begin errors++; $display("FAIL run_entry: state got %0d expected 1", game_state); end
  endtask

  task automatic test_first_spawn();
    logic [15:0] l;
    repeat (9) tick();
    checks++;
    if (enermy_alive[0] !== 1'b0) begin errors++; $display("FAIL early_spawn: alive0 got %0d expected 0 at frame 9", enermy_alive[0]); end
    tick();
    l = pre_lfsr;
    checks++;
    if (enermy_alive[0] !== 1'b1 || enemy_y[0] !== 10'd0) begin
      errors++; $display("FAIL spawn0: alive=%0d y=%0d expected alive=1 y=0", enermy_alive[0], enemy_y[0]);
    end
    checks++;
    if (enemy_size[0] !== exp_size(l) || enemy_x[0] !== exp_x(l)) begin
      errors++; $display("FAIL spawn0_pos: x=%0d size=%0d expected x=%0d size=%0d",
                         enemy_x[0], enemy_size[0], exp_x(l), exp_size(l));
    end
    checks++;
    if ({1'b0, enemy_x[0]} + {1'b0, enemy_size[0]} > 11'd640 || enemy_size[0] < 10'd8 || enemy_size[0] > 10'd39) begin
      errors++; $display("FAIL spawn0_bounds: x=%0d size=%0d expected x+size<=640, 8<=size<=39", enemy_x[0], enemy_size[0]);
    end
    tick();
    checks++;
    if (enemy_y[0] !== 10'd2) begin errors++; $display("FAIL first_move: y0 got %0d expected 2", enemy_y[0]); end
  endtask

  task automatic test_fill();
    logic [15:0] l;
    logic [9:0]  x0;
    x0 = enemy_x[0];
    for (int k = 1; k < 4; k++) begin
      while (frame < 10 * (k + 1)) tick();
      l = pre_lfsr;
      checks++;
      if (enermy_alive[k] !== 1'b1 || enemy_y[k] !== 10'd0 || enemy_x[k] !== exp_x(l) || enemy_size[k] !== exp_size(l)) begin
        errors++; $display("FAIL fill_slot%0d: alive=%0d y=%0d x=%0d size=%0d expected 1 0 %0d %0d", k,
                           enermy_alive[k], enemy_y[k], enemy_x[k], enemy_size[k], exp_x(l), exp_size(l));
      end
      if (k < 3) begin
        checks++;
        if (enermy_alive[k+1] !== 1'b0) begin errors++; $display("FAIL fill_order%0d: alive got %0d expected 0", k + 1, enermy_alive[k+1]); end
      end
    end
    while (frame < 50) tick();
    checks++;
    if (enermy_alive[0] !== 1'b1 || enermy_alive[1] !== 1'b1 || enermy_alive[2] !== 1'b1 || enermy_alive[3] !== 1'b1) begin
      errors++; $display("FAIL full_drop: alive=%0d%0d%0d%0d expected 1111",
                         enermy_alive[0], enermy_alive[1], enermy_alive[2], enermy_alive[3]);
    end
    checks++;
    if (enemy_y[0] !== 10'd80 || enemy_x[0] !== x0 || enemy_y[3] !== 10'd20) begin
      errors++; $display("FAIL full_motion: y0=%0d x0=%0d y3=%0d expected 80 %0d 20", enemy_y[0], enemy_x[0], enemy_y[3], x0);
    end
  endtask

  task automatic test_retire();
    logic [15:0] l;
    while (frame < 248) tick();
    checks++;
    if (enemy_y[0] !== 10'd476) begin errors++; $display("FAIL pre_retire: y0 got %0d expected 476", enemy_y[0]); end
    tick();
    checks++;
    if (enemy_y[0] !== 10'd478 || enermy_alive[0] !== 1'b1) begin
      errors++; $display("FAIL edge_y: y0=%0d alive=%0d expected 478 1", enemy_y[0], enermy_alive[0]);
    end
    tick();
    checks++;
    if (enermy_alive[0] !== 1'b0 || enemy_x[0] !== 10'd0 || enemy_y[0] !== 10'd0 || enemy_size[0] !== 10'd0) begin
      errors++; $display("FAIL retire0: alive=%0d x=%0d y=%0d size=%0d expected all 0",
                         enermy_alive[0], enemy_x[0], enemy_y[0], enemy_size[0]);
    end
    checks++;
    if (score !== 16'd1) begin errors++; $display("FAIL score_one: got %0d expected 1", score); end
    checks++;
    if (enemy_y[1] !== 10'd460) begin errors++; $display("FAIL y1_at250: got %0d expected 460", enemy_y[1]); end
    while (frame < 259) tick();
    checks++;
    if (enermy_alive[0] !== 1'b0) begin errors++; $display("FAIL no_reuse: alive0 got %0d expected 0", enermy_alive[0]); end
    tick();
    l = pre_lfsr;
    checks++;
    if (enermy_alive[0] !== 1'b1 || enemy_y[0] !== 10'd0 || enemy_size[0] !== exp_size(l) || enemy_x[0] !== exp_x(l)) begin
      errors++; $display("FAIL respawn0: alive=%0d y=%0d x=%0d size=%0d expected 1 0 %0d %0d",
                         enermy_alive[0], enemy_y[0], enemy_x[0], enemy_size[0], exp_x(l), exp_size(l));
    end
    checks++;
    if (enermy_alive[1] !== 1'b0 || score !== 16'd2 || speed !== 4'd2) begin
      errors++; $display("FAIL retire1: alive1=%0d score=%0d speed=%0d expected 0 2 2", enermy_alive[1], score, speed);
    end
  endtask

  task automatic test_freeze();
    logic [9:0]  sx [4];
    logic [9:0]  sy [4];
    logic [9:0]  ss [4];
    logic        sa [4];
    logic [15:0] sscore;
    logic        same;
    while (frame < 265) tick();
    for (int i = 0; i < 4; i++) begin
      sx[i] = enemy_x[i]; sy[i] = enemy_y[i]; ss[i] = enemy_size[i]; sa[i] = enermy_alive[i];
    end
    sscore = score;
    Ball_die = 1'b1;
    tick();
    Ball_die = 1'b0;
    checks++;
    if (game_state !== 2'd2) begin errors++; $display("FAIL freeze_state: got %0d expected 2", game_state); end
    for (int f = 0; f < 100; f++) begin
      same = (score === sscore) && (game_state === 2'd2);
      for (int i = 0; i < 4; i++)
        same = same && (enemy_x[i] === sx[i]) && (enemy_y[i] === sy[i]) && (enemy_size[i] === ss[i]) && (enermy_alive[i] === sa[i]);
      checks++;
      if (!same) begin
        errors++; $display("FAIL frozen_hold: frame %0d state=%0d score=%0d y0=%0d expected 2 %0d %0d",
                           f, game_state, score, enemy_y[0], sscore, sy[0]);
      end
      tick();
    end
  endtask

  task automatic test_idle_restart();
    game_run = 1'b0;
    tick();
    checks++;
    if (game_state !== 2'd0 || score !== 16'd2) begin
      errors++; $display("FAIL to_idle: state=%0d score=%0d expected 0 2", game_state, score);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (enermy_alive[i] !== 1'b0 || enemy_x[i] !== 10'd0 || enemy_y[i] !== 10'd0 || enemy_size[i] !== 10'd0) begin
        errors++; $display("FAIL idle_clear%0d: alive=%0d x=%0d y=%0d size=%0d expected all 0", i,
                           enermy_alive[i], enemy_x[i], enemy_y[i], enemy_size[i]);
      end
    end
    Ball_die = 1'b1;
    tick();
    Ball_die = 1'b0;
    checks++;
    if (game_state !== 2'd0) begin errors++; $display("FAIL idle_ignores_die: state got %0d expected 0", game_state); end
    game_run = 1'b1;
    tick();
    frame = 0;
    checks++;
    if (game_state !== 2'd1 || score !== 16'd0 || speed !== 4'd2) begin
      errors++; $display("FAIL restart: state=%0d score=%0d speed=%0d expected 1 0 2", game_state, score, speed);
    end
  endtask

  task automatic test_async_reset();
    while (frame < 10) tick();
    checks++;
    if (enermy_alive[0] !== 1'b1) begin errors++; $display("FAIL restart_spawn: alive0 got %0d expected 1", enermy_alive[0]); end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (game_state !== 2'd0 || enermy_alive[0] !== 1'b0 || enemy_x[0] !== 10'd0 || enemy_size[0] !== 10'd0) begin
      errors++; $display("FAIL async_reset: state=%0d alive0=%0d x0=%0d size0=%0d expected all 0",
                         game_state, enermy_alive[0], enemy_x[0], enemy_size[0]);
    end
    tick();
    Reset = 1'b0;
    tick();
    frame = 0;
    checks++;
    if (game_state !== 2'd1) begin errors++; $display("FAIL rerun_after_reset: state got %0d expected 1", game_state); end
  endtask

`ifdef METEOR_SPEEDUP_EN
  task automatic test_speedup();
    logic [15:0] last;
    int          exp_spd;
    int          budget;
    last   = score;
    budget = 0;
    while (score < 16'd56 && budget < 20000) begin
      tick();
      budget++;
      if (score !== last) begin
        exp_spd = 2 + int'(score) / 8;
        if (exp_spd > 7) exp_spd = 7;
        checks++;
        if (int'(speed) != exp_spd) begin
          errors++; $display("FAIL speedup: score=%0d speed got %0d expected %0d", score, speed, exp_spd);
        end
        last = score;
      end
    end
    checks++;
    if (score < 16'd56) begin errors++; $display("FAIL speedup_timeout: score got %0d expected >=56", score); end
    checks++;
    if (speed !== 4'd7) begin errors++; $display("FAIL speed_sat: got %0d expected 7", speed); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_spawn();
    test_fill();
    test_retire();
    test_freeze();
    test_idle_restart();
    test_async_reset();
`ifdef METEOR_SPEEDUP_EN
    test_speedup();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/meteor_field.md
# meteor_field

Meteorite generator and mover for the dodge game. Owns four meteor slots, spawns them at pseudo-random X positions and sizes, drops them down the screen each frame, retires them at the bottom edge and counts dodges. Sits directly upstream of the player block and drives its `enemy_x`, `enemy_y`, `enemy_size` and `enermy_alive` arrays. It consumes `Ball_die` back from the player block to freeze the field on a hit.

## Interface
- `SPAWN_PERIOD`, 60: frames between spawn attempts.
- `SIZE_MIN`, 8: minimum meteor edge length in pixels; the actual size is SIZE_MIN..SIZE_MIN+31.
- `Y_LIMIT`, 479: a meteor retires when its top edge would exceed this value.
- `X_SPAN`, 640: screen width.
- `BASE_SPEED`, 2: falling step in pixels per frame.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `SPEEDUP_DODGES`, 8: dodges per speed increment. Used only with the macro.

Ports:
- `frame_clk`  in  1  frame clock; all state updates on posedge.
- `Reset`  in  1  asynchronous, active-high.
- `game_run`  in  1  level; 1 = play requested.
- `Ball_die`  in  1  hit flag from the player block.
- `enemy_x[4]`  out  10  left edge per slot.
- `enemy_y[4]`  out  10  top edge per slot.
- `enemy_size[4]`  out  10  edge length per slot.
- `enermy_alive[4]`  out  1  slot active.
- `score`  out  16  meteors dodged this game; saturates at 16'hFFFF.
- `speed`  out  4  current fall step.
- `game_state`  out  2  0 = IDLE, 1 = RUN, 2 = FROZEN.

## Operation
- **LFSR**
  - 16-bit Galois LFSR, taps 16'hB400.
  - Advances on every frame_clk edge in all states.
- **FSM**
  - IDLE → RUN when `game_run`=1. On this transition: `score`←0, `speed`←BASE_SPEED, spawn counter←0.
  - RUN → FROZEN when `Ball_die`=1. This takes priority over everything else on that edge: no motion, spawn or score change.
  - RUN → IDLE when `game_run`=0.
  - FROZEN → IDLE when `game_run`=0.
  - In IDLE: every slot has alive=0 and x=y=size=0. `score` is held so it can be displayed.
  - In FROZEN: all slot registers, `score` and `speed` hold. `Ball_die` is ignored outside RUN.
- **Motion** (RUN, per alive slot)
  - Compute y_next = y + speed in 11 bits.
  - If y_next > Y_LIMIT: alive←0, x, y and size←0, `score`+1 (saturating).
  - Otherwise y←y_next.
  - If several slots retire on the same edge, `score` increases by the count of retiring slots.
- **Spawn** (RUN)
  - The counter counts 0..SPAWN_PERIOD-1 and wraps. A spawn attempt occurs on the edge where the counter equals SPAWN_PERIOD-1.
  - The target is the lowest-index slot whose registered alive=0. A slot retiring on the same edge is not eligible.
  - If no slot is free, the attempt is dropped and the counter still wraps.
  - size = SIZE_MIN + lfsr[14:10].
  - raw = lfsr[9:0]. x = raw if raw ≤ X_SPAN − size, else raw − 512.
  - y = 0 and alive = 1.
  - This guarantees x + size ≤ X_SPAN.

## Timing
- All outputs are registered and change only on posedge frame_clk or Reset.
- Reset values:
  - All `enermy_alive`=0; all x, y and size = 0.
  - `score`=0, `speed`=BASE_SPEED, `game_state`=IDLE.
  - LFSR=LFSR_SEED, spawn counter=0.
- Reset mid-RUN or mid-FROZEN returns immediately to the reset values.
- `game_run` rising: RUN on the next edge. The first spawn is SPAWN_PERIOD edges after entering RUN.
- A spawned meteor reads y=0 for one frame and moves by `speed` on every following edge.
- `Ball_die` is sampled once: the edge where `Ball_die`=1 enters FROZEN. Outputs from that edge onward equal the values before it.

## Configuration
- **`METEOR_SPEEDUP_EN` defined**
  - A dodge counter increments with every retirement.
  - Each time it crosses a multiple of SPEEDUP_DODGES, `speed`+1, saturating at 7.
  - The counter and `speed` reset on IDLE→RUN.
  - The new speed takes effect on the edge after the increment.
- **`METEOR_SPEEDUP_EN` undefined**
  - `speed` is constant BASE_SPEED and there is no dodge counter.

## Test plan
- Assert Reset with `game_run`=1 → all alive=0, x/y/size=0, `score`=0, `speed`=2, `game_state`=0. After release: RUN on the next edge.
- SPAWN_PERIOD=10, `game_run`=1 → slot0 alive 10 edges after RUN, y=0, 8≤size≤39, x+size≤640. One edge later y=2.
- SPAWN_PERIOD=10 for 50 frames → slots 0,1,2,3 fill in order at frames 10/20/30/40. The frame-50 attempt is dropped and all alive states are unchanged.
- Slot at y=476, speed 2 → y=478, then alive=0 with `score`=1. At y=478 the slot is not reused until the next spawn attempt.
- Pulse `Ball_die` in RUN → `game_state`=2, positions and `score` unchanged for 100 frames, no spawns.
  - Then `game_run`=0 → IDLE, all cleared, `score` retained.
  - Then `game_run`=1 → `score`=0.
- With `METEOR_SPEEDUP_EN` defined: 8 retirements → `speed`=3; 48 retirements → `speed`=7; 56 retirements → `speed` stays 7.
